// File: rtl/eespfal_pkg.sv
// eespfal_pkg: shared constants for the EESPFAL switch driver slice.
// Holds the FSM state codes, default array width and counter width helper.
package eespfal_pkg;

  localparam int BIT_SIZE_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_DIS  = 3'd1;
  localparam state_t S_EVAL = 3'd2;
  localparam state_t S_HOLD = 3'd3;
  localparam state_t S_REC  = 3'd4;

  function automatic int ctr_w(input int p);
    return (p < 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/eespfal_phase_ctr.sv
// eespfal_phase_ctr: modulo-P phase counter with synchronous clear.
// Ports: clk, rst_n (sync, active-low), clr in; last out (count == P-1).
module eespfal_phase_ctr
  import eespfal_pkg::*;
#(
  parameter int unsigned P = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic last
);

  localparam int W = ctr_w(P);
  localparam logic [W-1:0] MAX = W'(P - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = (cnt == MAX);

endmodule

// File: rtl/eespfal_switch_driver.sv
// eespfal_switch_driver: sequences one EESPFAL switch array and checks s/s_bar.
// In: start/abort/bit_en/x_in/k_in, s/s_bar. Out: ready, result, phase drives.
module eespfal_switch_driver
  import eespfal_pkg::*;
#(
  parameter int unsigned BIT_SIZE     = BIT_SIZE_DEF,
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BIT_SIZE-1:0] bit_en,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  output logic                ready,
  output logic                res_valid,
  output logic [BIT_SIZE-1:0] s_out,
  output logic [BIT_SIZE-1:0] rail_err,
  output logic [BIT_SIZE-1:0] mismatch,
  output logic [BIT_SIZE-1:0] CLK,
  output logic [BIT_SIZE-1:0] Dis,
  output logic [BIT_SIZE-1:0] x,
  output logic [BIT_SIZE-1:0] x_bar,
  output logic [BIT_SIZE-1:0] k,
  output logic [BIT_SIZE-1:0] k_bar,
  output logic                Dis_Phase,
  input  logic [BIT_SIZE-1:0] s,
  input  logic [BIT_SIZE-1:0] s_bar
);

  typedef logic [BIT_SIZE-1:0] vec_t;

  state_t st_q, st_d;
  logic   last, acc, stop, samp, pend_q, clr;
  logic   nd_dis, nd_act, ph_d;
  vec_t   en_q, x_q, k_q, en_d, err_w;
  vec_t   clk_d, dis_d, x_d, xb_d, k_d, kb_d;

  assign acc  = (st_q == S_IDLE) && start;
  assign stop = abort && (st_q == S_DIS ||
                          st_q == S_EVAL ||
                          st_q == S_HOLD);
  assign samp = (st_q == S_HOLD) && last && !abort;

  always_comb begin
    st_d = st_q;
    if (stop) begin
      st_d = S_REC;
    end else begin
      unique case (st_q)
        S_IDLE:  if (start) st_d = S_DIS;
        S_DIS:   if (last)  st_d = S_EVAL;
        S_EVAL:  if (last)  st_d = S_HOLD;
        S_HOLD:  if (last)  st_d = S_REC;
        S_REC:   if (last)  st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase
    end
  end

  // Counter is held at zero while idle so DIS always starts at 0.
  assign clr = (st_d != st_q) || (st_q == S_IDLE);

  eespfal_phase_ctr #(
    .P(PHASE_CYCLES)
  ) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .last (last)
  );

  // Drives are decoded from the next state and registered, so the
  // array sees glitch-free levels aligned with the state.
  assign nd_dis = (st_d == S_DIS);
  assign nd_act = (st_d == S_EVAL) || (st_d == S_HOLD);
  assign en_d   = acc ? bit_en : en_q;

  always_comb begin
    clk_d = '0;
    dis_d = '0;
    x_d   = '0;
    xb_d  = '0;
    k_d   = '0;
    kb_d  = '0;
    ph_d  = 1'b0;
    unique case (1'b1)
      nd_dis: begin
        dis_d = en_d;
        ph_d  = 1'b1;
      end
      nd_act: begin
        clk_d = en_q;
        x_d   = x_q & en_q;
        xb_d  = ~x_q & en_q;
        k_d   = k_q & en_q;
        kb_d  = ~k_q & en_q;
      end
      default: ;
    endcase
  end

  assign err_w = en_q & ~(s ^ s_bar);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      ready     <= 1'b1;
      res_valid <= 1'b0;
      pend_q    <= 1'b0;
      en_q      <= '0;
      x_q       <= '0;
      k_q       <= '0;
      s_out     <= '0;
      rail_err  <= '0;
      mismatch  <= '0;
      CLK       <= '0;
      Dis       <= '0;
      x         <= '0;
      x_bar     <= '0;
      k         <= '0;
      k_bar     <= '0;
      Dis_Phase <= 1'b0;
    end else begin
      st_q      <= st_d;
      ready     <= (st_d == S_IDLE);
      CLK       <= clk_d;
      Dis       <= dis_d;
      x         <= x_d;
      x_bar     <= xb_d;
      k         <= k_d;
      k_bar     <= kb_d;
      Dis_Phase <= ph_d;
      if (acc) begin
        en_q <= bit_en;
        x_q  <= x_in;
        k_q  <= k_in;
      end
      if (samp) begin
        s_out    <= s & en_q;
        rail_err <= err_w;
        mismatch <= en_q & ~err_w & (s ^ x_q ^ k_q);
      end
      // pend marks a completed sample; an aborted run never sets it.
      if (samp) begin
        pend_q <= 1'b1;
      end else if (st_q == S_REC && last) begin
        pend_q <= 1'b0;
      end
      res_valid <= (st_q == S_REC) && last && pend_q;
    end
  end

endmodule

// File: tb/tb_eespfal_switch_driver.sv
// tb_eespfal_switch_driver: random + directed bench with phase model.
// Scoreboard queue holds expected results popped on res_valid.
module tb_eespfal_switch_driver;

  localparam int P  = 4;
  localparam int BS = 4;

  typedef logic [BS-1:0] v_t;
  typedef logic [3*BS-1:0] r_t;

  typedef struct {
    int t0;
    int ab;
    int rs;
    v_t en;
    v_t x;
    v_t k;
    v_t s;
    v_t sb;
  } op_t;

  typedef struct {
    int cyc;
    r_t r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  v_t   bit_en = '0;
  v_t   x_in = '0;
  v_t   k_in = '0;
  v_t   s = '0;
  v_t   s_bar = '0;

  logic ready, res_valid, Dis_Phase;
  v_t   s_out, rail_err, mismatch;
  v_t   CLK, Dis, x, x_bar, k, k_bar;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rst_at = -100;
  bit   chk_on = 1'b0;
  r_t   hold = '0;
  op_t  ops[$];
  exp_t sbq[$];

  eespfal_switch_driver #(
    .BIT_SIZE    (BS),
    .PHASE_CYCLES(P)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bit_en   (bit_en),
    .x_in     (x_in),
    .k_in     (k_in),
    .ready    (ready),
    .res_valid(res_valid),
    .s_out    (s_out),
    .rail_err (rail_err),
    .mismatch (mismatch),
    .CLK      (CLK),
    .Dis      (Dis),
    .x        (x),
    .x_bar    (x_bar),
    .k        (k),
    .k_bar    (k_bar),
    .Dis_Phase(Dis_Phase),
    .s        (s),
    .s_bar    (s_bar)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Phase of an op d cycles after its accept: 0 idle, 1 DIS, 2 EVAL,
  // 3 HOLD, 4 REC. ab/rs are the cycle offsets of abort/reset (0 = none).
  function automatic int ph(input int d, input int ab, input int rs);
    if (d <= 0) return 0;
    if (rs > 0 && d > rs) return 0;
    if (ab > 0 && d > ab) return (d <= ab + P) ? 4 : 0;
    if (d > 4 * P) return 0;
    return (d - 1) / P + 1;
  endfunction

  function automatic r_t res_of(input op_t o);
    v_t so, re, mm;
    so = '0;
    re = '0;
    mm = '0;
    for (int i = 0; i < BS; i++) begin
      if (o.en[i]) begin
        so[i] = o.s[i];
        if (o.s[i] == o.sb[i]) re[i] = 1'b1;
        else if (o.s[i] != (o.x[i] ^ o.k[i])) mm[i] = 1'b1;
      end
    end
    return {so, re, mm};
  endfunction

  function automatic bit samp_ok(input op_t o);
    return o.ab == 0 && (o.rs == 0 || o.rs > 3 * P);
  endfunction

  function automatic bit rv_ok(input op_t o);
    return o.ab == 0 && (o.rs == 0 || o.rs > 4 * P);
  endfunction

  // Array model: valid values only while HOLD, noise otherwise.
  initial forever begin
    op_t o;
    @(posedge clk);
    #2;
    if (ops.size() > 0) begin
      o = ops[ops.size() - 1];
      if (ph(cyc - o.t0, o.ab, o.rs) == 3) begin
        s = o.s;
        s_bar = o.sb;
      end else begin
        s = v_t'($urandom);
        s_bar = v_t'($urandom);
      end
    end
  end

  // Per-cycle reference of every output.
  initial forever begin
    op_t a;
    int pa, d, p;
    logic erv, edp;
    v_t ec, ed, ex, exb, ek, ekb;
    logic [38:0] ev, av;
    @(negedge clk);
    if (chk_on) begin
      pa = 0;
      erv = 1'b0;
      if (rst_at == cyc - 1) hold = '0;
      foreach (ops[i]) begin
        d = cyc - ops[i].t0;
        p = ph(d, ops[i].ab, ops[i].rs);
        if (p != 0) begin
          pa = p;
          a = ops[i];
        end
        if (d == 3 * P + 1 && samp_ok(ops[i])) hold = res_of(ops[i]);
        if (d == 4 * P + 1 && rv_ok(ops[i])) erv = 1'b1;
      end
      edp = 1'b0;
      ec = '0;
      ed = '0;
      ex = '0;
      exb = '0;
      ek = '0;
      ekb = '0;
      if (pa == 1) begin
        ed = a.en;
        edp = 1'b1;
      end else if (pa == 2 || pa == 3) begin
        ec = a.en;
        ex = a.x & a.en;
        exb = ~a.x & a.en;
        ek = a.k & a.en;
        ekb = ~a.k & a.en;
      end
      ev = {pa == 0, erv, edp, ec, ed, ex, exb, ek, ekb, hold};
      av = {ready, res_valid, Dis_Phase, CLK, Dis,
            x, x_bar, k, k_bar, s_out, rail_err, mismatch};
      tests++;
      if (av !== ev) begin
        fails++;
        $display("FAIL outputs cycle %0d: got %h expected %h",
                 cyc, av, ev);
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (chk_on && res_valid === 1'b1) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL result: res_valid at cycle %0d, none expected",
                 cyc);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || {s_out, rail_err, mismatch} !== e.r) begin
          fails++;
          $display("FAIL result: got %h at cycle %0d expected %h at %0d",
                   {s_out, rail_err, mismatch}, cyc, e.r, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      abort = ($urandom_range(0, 1) == 1);
      step();
    end
    abort = 1'b0;
  endtask

  task automatic do_op(input v_t en, input v_t xv, input v_t kv,
                       input v_t sv, input v_t sbv, input int ab,
                       input int rs, input bit keep, input bit noise);
    op_t o;
    exp_t e;
    int d, total;
    o.t0 = cyc;
    o.ab = ab;
    o.rs = 0;
    o.en = en;
    o.x = xv;
    o.k = kv;
    o.s = sv;
    o.sb = sbv;
    bit_en = en;
    x_in = xv;
    k_in = kv;
    start = 1'b1;
    ops.push_back(o);
    if (ab == 0) begin
      e.cyc = cyc + 4 * P + 1;
      e.r = res_of(o);
      sbq.push_back(e);
    end
    total = (ab > 0) ? ab + P : 4 * P;
    step();
    start = keep;
    bit_en = v_t'($urandom);
    x_in = v_t'($urandom);
    k_in = v_t'($urandom);
    d = cyc - o.t0;
    while (d <= total) begin
      abort = (ab > 0 && d == ab) || (noise && d == 3 * P + 2);
      if (rs > 0 && d == rs) begin
        rst_n = 1'b0;
        rst_at = cyc;
        o = ops.pop_back();
        o.rs = rs;
        ops.push_back(o);
        if (ab == 0) void'(sbq.pop_back());
        start = 1'b0;
        abort = 1'b0;
        step();
        rst_n = 1'b1;
        return;
      end
      step();
      d = cyc - o.t0;
    end
    abort = noise;
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    do_op(4'hF, 4'hA, 4'h6, 4'hC, 4'h3, 0, 0, 1'b0, 1'b0);
    do_op(4'hF, 4'hA, 4'h6, 4'hC, 4'hF, 0, 0, 1'b0, 1'b0);
    do_op(4'h5, 4'hF, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 1'b0);
    idle(2);
    do_op(4'hF, 4'h3, 4'h5, 4'h6, 4'h9, 6, 0, 1'b0, 1'b0);
    idle(3);
    do_op(4'hE, 4'h1, 4'h7, 4'h6, 4'h9, 0, 0, 1'b1, 1'b0);
    do_op(4'h7, 4'h8, 4'h2, 4'hA, 4'h5, 0, 0, 1'b1, 1'b0);
    do_op(4'hB, 4'h4, 4'hC, 4'h8, 4'h8, 0, 0, 1'b0, 1'b0);
    do_op(4'hF, 4'h2, 4'h2, 4'h1, 4'hE, P, 0, 1'b0, 1'b0);
    do_op(4'hF, 4'h2, 4'h2, 4'h1, 4'hE, 3 * P, 0, 1'b0, 1'b0);
    do_op(4'hF, 4'h2, 4'h2, 4'h1, 4'hE, 1, 0, 1'b0, 1'b0);
    do_op(4'hC, 4'h9, 4'h3, 4'hA, 4'h5, 0, 0, 1'b0, 1'b1);
    idle(2);
    do_op(4'h0, 4'hF, 4'hF, 4'h7, 4'h7, 0, 0, 1'b0, 1'b0);
    do_op(4'hF, 4'hA, 4'h6, 4'hC, 4'h3, 0, 9, 1'b0, 1'b0);
    do_op(4'hF, 4'hA, 4'h6, 4'hC, 4'h3, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++) begin
      v_t en, xv, kv, sv, sbv;
      int ab, md;
      bit kp;
      en = v_t'($urandom);
      xv = v_t'($urandom);
      kv = v_t'($urandom);
      md = $urandom_range(0, 3);
      if (md < 2) begin
        sv = xv ^ kv;
        if (md == 1) sv = sv ^ v_t'($urandom);
        sbv = ~sv;
      end else begin
        sv = v_t'($urandom);
        sbv = v_t'($urandom);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * P) : 0;
      kp = (n < 29) && ($urandom_range(0, 1) == 1);
      do_op(en, xv, kv, sv, sbv, ab, 0, kp,
            $urandom_range(0, 1) == 1);
      if (!kp) idle($urandom_range(0, 2));
    end
    idle(6);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d results never seen, expected 0",
               sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
